// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory-access unit.
package lc3_mem_pkg;

    // Everything at or above this address is decoded as memory-mapped I/O
    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR_A    = 16'hFE00;
    localparam logic [15:0] KBDR_A    = 16'hFE02;
    localparam logic [15:0] DSR_A     = 16'hFE04;
    localparam logic [15:0] DDR_A     = 16'hFE06;
    localparam logic [15:0] MCR_A     = 16'hFFFE;

    // Reset values of the status/control registers
    localparam logic [15:0] KBSR_RST  = 16'h0000;
    localparam logic [15:0] DSR_RST   = 16'h8000;
    localparam logic [15:0] MCR_RST   = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_IO,
        ST_DONE
    } state_t;

    // One MMIO register access, presented for exactly one cycle
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } io_req_t;

    function automatic logic is_mmio(input logic [15:0] a);
        return a >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Memory-mapped I/O registers: keyboard, display and machine control.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  io_req_t     io_req,
    output logic [15:0] io_rdata,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_kb_ready,
    output logic        o_kb_irq,
    output logic        o_dd_valid,
    output logic [7:0]  o_dd_data,
    input  logic        i_dd_ready,
    output logic        o_mcr_run
);

    logic        kb_rdy;    // KBSR[15]
    logic        kb_ie;     // KBSR[14]
    logic [7:0]  kbdr;
    logic        dsr_rdy;   // DSR[15]
    logic [15:0] ddr;
    logic [15:0] mcr;

    logic kbdr_rd, kb_take, wr_kbsr, wr_ddr, wr_mcr;

    assign kbdr_rd = io_req.rd && (io_req.addr == KBDR_A);
    assign wr_kbsr = io_req.wr && (io_req.addr == KBSR_A);
    assign wr_ddr  = io_req.wr && (io_req.addr == DDR_A);
    assign wr_mcr  = io_req.wr && (io_req.addr == MCR_A);

    // A KBDR read clears the ready flag; ready is held low in that cycle
    // too, so a char offered alongside the read is never half-accepted.
    // kbdr_rd comes straight off FSM registers, so this stays glitch-free.
    assign o_kb_ready = ~kb_rdy & ~kbdr_rd;
    assign kb_take    = i_kb_valid & o_kb_ready;
    assign o_kb_irq   = kb_rdy & kb_ie;
    assign o_dd_valid = ~dsr_rdy;
    assign o_dd_data  = ddr[7:0];
    assign o_mcr_run  = mcr[15];

    // Register read mux; unmapped MMIO addresses read as zero
    always_comb begin
        io_rdata = '0;
        case (io_req.addr)
            KBSR_A:  io_rdata = {kb_rdy, kb_ie, 14'h0};
            KBDR_A:  io_rdata = {8'h00, kbdr};
            DSR_A:   io_rdata = {dsr_rdy, 15'h0};
            DDR_A:   io_rdata = ddr;
            MCR_A:   io_rdata = mcr;
            default: io_rdata = '0;
        endcase
    end

    // Register storage, bus writes and device handshakes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kb_rdy  <= KBSR_RST[15];
            kb_ie   <= KBSR_RST[14];
            kbdr    <= '0;
            dsr_rdy <= DSR_RST[15];
            ddr     <= '0;
            mcr     <= MCR_RST;
        end else begin
            if (kbdr_rd) begin
                kb_rdy <= 1'b0;
            end else if (kb_take) begin
                kb_rdy <= 1'b1;
                kbdr   <= i_kb_data;
            end
            if (wr_kbsr) kb_ie <= io_req.wdata[14];

            // A DDR write while the display is still busy is dropped
            if (wr_ddr && dsr_rdy) begin
                ddr     <= io_req.wdata;
                dsr_rdy <= 1'b0;
            end else if (o_dd_valid && i_dd_ready) begin
                dsr_rdy <= 1'b1;
            end

            if (wr_mcr) mcr <= io_req.wdata;
        end
    end

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access unit: owns MAR/MDR, sequences memory and MMIO cycles.
module lc3_mem_access
    import lc3_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255   // MEM_WAIT cycles before abort, 0 = never
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld_mar,
    input  logic [15:0] i_mar_in,
    input  logic        i_ld_mdr,
    input  logic [15:0] i_mdr_in,
    input  logic        i_mem_en,
    input  logic        i_rw,
    output logic [15:0] o_mar,
    output logic [15:0] o_mdr,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    output logic        o_kb_ready,
    output logic        o_kb_irq,
    output logic        o_dd_valid,
    output logic [7:0]  o_dd_data,
    input  logic        i_dd_ready,
    output logic        o_mcr_run
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] mar, mdr;
    logic [15:0] acc_addr, acc_wdata;   // snapshot of MAR/MDR at accept
    logic        acc_we;
    logic [15:0] wait_cnt;
    logic        to_flag;
    logic        req_q, ready_q, err_q;
    io_req_t     io_req;
    logic [15:0] io_rdata;

    assign o_mar       = mar;
    assign o_mdr       = mdr;
    assign o_ready     = ready_q;
    assign o_err       = err_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = req_q & acc_we;
    assign o_mem_addr  = acc_addr;
    assign o_mem_wdata = acc_wdata;

    // MMIO access strobe for the single IO cycle
    always_comb begin
        io_req       = '0;
        io_req.rd    = (state == ST_IO) && !acc_we;
        io_req.wr    = (state == ST_IO) && acc_we;
        io_req.addr  = acc_addr;
        io_req.wdata = acc_wdata;
    end

    lc3_mmio_regs u_mmio (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .io_req     (io_req),
        .io_rdata   (io_rdata),
        .i_kb_valid (i_kb_valid),
        .i_kb_data  (i_kb_data),
        .o_kb_ready (o_kb_ready),
        .o_kb_irq   (o_kb_irq),
        .o_dd_valid (o_dd_valid),
        .o_dd_data  (o_dd_data),
        .i_dd_ready (i_dd_ready),
        .o_mcr_run  (o_mcr_run)
    );

    // Access FSM with MAR/MDR, timeout counter and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            mar       <= '0;
            mdr       <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_we    <= 1'b0;
            wait_cnt  <= '0;
            to_flag   <= 1'b0;
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ld_mar) mar <= i_mar_in;
                    if (i_ld_mdr) mdr <= i_mdr_in;
                    // Snapshot takes the pre-load MAR/MDR, so a same-cycle
                    // load affects only the next access
                    if (i_mem_en) begin
                        acc_addr  <= mar;
                        acc_wdata <= mdr;
                        acc_we    <= i_rw;
                        wait_cnt  <= '0;
                        to_flag   <= 1'b0;
                        if (is_mmio(mar)) begin
                            state <= ST_IO;
                        end else begin
                            state <= ST_MEM_WAIT;
                            req_q <= 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack on the last allowed cycle still wins over the timeout
                    if (i_mem_ack) begin
                        if (!acc_we) mdr <= i_mem_rdata;
                        req_q <= 1'b0;
                        state <= ST_DONE;
                    end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
                        if (!acc_we) mdr <= '0;
                        to_flag <= 1'b1;
                        req_q   <= 1'b0;
                        state   <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_IO: begin
                    if (!acc_we) mdr <= io_rdata;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    err_q   <= to_flag;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Randomized, model-checked bench for lc3_mem_access.
module tb_lc3_mem_access;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_ld_mar = 1'b0, i_ld_mdr = 1'b0, i_mem_en = 1'b0, i_rw = 1'b0;
    logic [15:0] i_mar_in = '0, i_mdr_in = '0;
    logic [15:0] i_mem_rdata = '0;
    logic        i_mem_ack = 1'b0;
    logic        i_kb_valid = 1'b0;
    logic [7:0]  i_kb_data = '0;
    logic        i_dd_ready = 1'b0;
    logic [15:0] o_mar, o_mdr, o_mem_addr, o_mem_wdata;
    logic        o_ready, o_err, o_mem_req, o_mem_we;
    logic        o_kb_ready, o_kb_irq, o_dd_valid, o_mcr_run;
    logic [7:0]  o_dd_data;

    always #5 i_clk = ~i_clk;

    lc3_mem_access #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_ld_mar(i_ld_mar), .i_mar_in(i_mar_in),
        .i_ld_mdr(i_ld_mdr), .i_mdr_in(i_mdr_in),
        .i_mem_en(i_mem_en), .i_rw(i_rw),
        .o_mar(o_mar), .o_mdr(o_mdr), .o_ready(o_ready), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .i_kb_valid(i_kb_valid), .i_kb_data(i_kb_data),
        .o_kb_ready(o_kb_ready), .o_kb_irq(o_kb_irq),
        .o_dd_valid(o_dd_valid), .o_dd_data(o_dd_data),
        .i_dd_ready(i_dd_ready), .o_mcr_run(o_mcr_run)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mar, m_mdr, m_ddr, m_mcr;
    logic [7:0]  m_kbdr;
    logic        m_kb_rdy, m_kb_ie, m_dsr_rdy;
    logic [15:0] m_mem [logic [15:0]];   // what memory should hold
    logic [15:0] e_mem [logic [15:0]];   // what the external responder holds

    function automatic logic [15:0] mem_default(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : mem_default(a);
    endfunction

    task automatic mdl_reset();
        m_mar = '0; m_mdr = '0; m_ddr = '0; m_kbdr = '0;
        m_mcr = 16'h8000; m_kb_rdy = 1'b0; m_kb_ie = 1'b0; m_dsr_rdy = 1'b1;
    endtask

    // ---------------- external memory responder ----------------
    int resp_delay = 0;
    int resp_cnt = 0;
    always @(negedge i_clk) begin
        if (!o_mem_req) begin
            resp_cnt  = 0;
            i_mem_ack = 1'b0;
        end else begin
            resp_cnt = resp_cnt + 1;
            if (resp_cnt == resp_delay + 1) begin
                i_mem_ack = 1'b1;
                if (o_mem_we) e_mem[o_mem_addr] = o_mem_wdata;
                i_mem_rdata = e_mem.exists(o_mem_addr) ? e_mem[o_mem_addr] : mem_default(o_mem_addr);
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = 16'($urandom);
            end
        end
    end

    // ---------------- steady-state compare ----------------
    logic quiet = 1'b0;
    always @(negedge i_clk) begin
        if (quiet && i_rst_n) begin
            check("mar",      32'(o_mar),      32'(m_mar));
            check("mdr",      32'(o_mdr),      32'(m_mdr));
            check("kb_ready", 32'(o_kb_ready), 32'(!m_kb_rdy));
            check("kb_irq",   32'(o_kb_irq),   32'(m_kb_rdy & m_kb_ie));
            check("dd_valid", 32'(o_dd_valid), 32'(!m_dsr_rdy));
            check("dd_data",  32'(o_dd_data),  32'(m_ddr[7:0]));
            check("mcr_run",  32'(o_mcr_run),  32'(m_mcr[15]));
            check("idle_pulses", 32'({o_ready, o_err, o_mem_req}), 32'd0);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
        #1;
    endtask

    task automatic kb_send(input logic [7:0] ch);
        quiet = 1'b0;
        i_kb_valid = 1'b1; i_kb_data = ch;
        @(posedge i_clk); #1;
        i_kb_valid = 1'b0;
        if (!m_kb_rdy) begin m_kb_rdy = 1'b1; m_kbdr = ch; end
        quiet = 1'b1;
    endtask

    task automatic dd_consume();
        quiet = 1'b0;
        i_dd_ready = 1'b1;
        @(posedge i_clk); #1;
        i_dd_ready = 1'b0;
        if (!m_dsr_rdy) m_dsr_rdy = 1'b1;
        quiet = 1'b1;
    endtask

    // Load MAR/MDR, start an access, then follow it to o_ready
    task automatic access(input logic [15:0] a, input logic rw, input logic [15:0] wd,
                          input int d, input logic decoy_en, input logic [15:0] decoy);
        logic [15:0] rdv;
        logic        exp_err, saw, mmio;
        int          exp_lat, exp_req, cyc, nreq;
        quiet = 1'b0;
        i_ld_mar = 1'b1; i_mar_in = a; i_ld_mdr = 1'b1; i_mdr_in = wd;
        @(posedge i_clk); #1;
        i_ld_mdr = 1'b0; i_ld_mar = decoy_en; i_mar_in = decoy;
        i_mem_en = 1'b1; i_rw = rw; resp_delay = d;
        @(posedge i_clk); #1;
        i_ld_mar = 1'b0; i_mem_en = 1'b0;
        m_mar = decoy_en ? decoy : a;
        m_mdr = wd;
        mmio = (a >= 16'hFE00);
        exp_err = 1'b0;
        if (mmio) begin
            exp_lat = 2; exp_req = 0;
            rdv = '0;
            case (a)
                16'hFE00: begin rdv = {m_kb_rdy, m_kb_ie, 14'h0}; if (rw) m_kb_ie = wd[14]; end
                16'hFE02: begin rdv = {8'h00, m_kbdr}; if (!rw) m_kb_rdy = 1'b0; end
                16'hFE04: rdv = {m_dsr_rdy, 15'h0};
                16'hFE06: begin rdv = m_ddr; if (rw && m_dsr_rdy) begin m_ddr = wd; m_dsr_rdy = 1'b0; end end
                16'hFFFE: begin rdv = m_mcr; if (rw) m_mcr = wd; end
                default:  rdv = '0;
            endcase
            if (!rw) m_mdr = rdv;
        end else if (d < TO) begin
            exp_lat = d + 2; exp_req = d + 1;
            if (rw) m_mem[a] = wd; else m_mdr = m_rd(a);
        end else begin
            exp_lat = TO + 1; exp_req = TO; exp_err = 1'b1;
            if (!rw) m_mdr = '0;
        end
        cyc = 0; nreq = 0; saw = 1'b0;
        while (1) begin
            @(negedge i_clk);
            if (o_mem_req) begin
                nreq++;
                if (!saw) begin
                    saw = 1'b1;
                    check("mem_we",    32'(o_mem_we),    32'(rw));
                    check("mem_addr",  32'(o_mem_addr),  32'(a));
                    check("mem_wdata", 32'(o_mem_wdata), 32'(wd));
                end
            end
            if (o_ready || cyc > 40) break;
            @(posedge i_clk);
            cyc++;
        end
        check("ready_latency", 32'(cyc),   32'(exp_lat));
        check("err",           32'(o_err), 32'(exp_err));
        check("req_cycles",    32'(nreq),  32'(exp_req));
        check("mdr_at_ready",  32'(o_mdr), 32'(m_mdr));
        #1;
        quiet = 1'b1;
    endtask

    logic [15:0] mem_tbl  [6] = '{16'h0000, 16'h3000, 16'h3001, 16'h3002, 16'hFDFF, 16'h1234};
    logic [15:0] mmio_tbl [8] = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFFFE, 16'hFE01, 16'hFE08, 16'hFFFF};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [15:0] a;
        mdl_reset();
        repeat (3) @(negedge i_clk);
        // reset state
        check("rst_mar",      32'(o_mar),      32'd0);
        check("rst_mdr",      32'(o_mdr),      32'd0);
        check("rst_mcr_run",  32'(o_mcr_run),  32'd1);
        check("rst_kb_ready", 32'(o_kb_ready), 32'd1);
        check("rst_dd_valid", 32'(o_dd_valid), 32'd0);
        check("rst_pulses",   32'({o_ready, o_err, o_mem_req}), 32'd0);
        i_rst_n = 1'b1;
        #1 quiet = 1'b1;
        idle(2);

        // memory write then read
        access(16'h3000, 1'b1, 16'h1234, 2, 1'b0, 16'h0);
        check("t1_mem_written", 32'(e_mem[16'h3000]), 32'h1234);
        idle(1);
        m_mem[16'h3000] = 16'hBEEF; e_mem[16'h3000] = 16'hBEEF;
        access(16'h3000, 1'b0, 16'h5555, 1, 1'b0, 16'h0);
        check("t2_mdr", 32'(o_mdr), 32'hBEEF);
        idle(1);

        // keyboard
        kb_send(8'h41);
        idle(1);
        check("t3_kb_ready", 32'(o_kb_ready), 32'd0);
        access(16'hFE00, 1'b0, 16'h0, 0, 1'b0, 16'h0);
        check("t3_kbsr", 32'(o_mdr), 32'h8000);
        access(16'hFE02, 1'b0, 16'h0, 0, 1'b0, 16'h0);
        check("t3_kbdr", 32'(o_mdr), 32'h0041);
        idle(1);
        check("t3_kb_ready_after", 32'(o_kb_ready), 32'd1);

        // display
        access(16'hFE06, 1'b1, 16'h0048, 0, 1'b0, 16'h0);
        check("t4_dd_valid", 32'(o_dd_valid), 32'd1);
        check("t4_dd_data",  32'(o_dd_data),  32'h48);
        access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, 16'h0);
        check("t4_dsr_busy", 32'(o_mdr), 32'h0000);
        access(16'hFE06, 1'b1, 16'h0055, 0, 1'b0, 16'h0);
        check("t4_dropped", 32'(o_dd_data), 32'h48);
        dd_consume();
        access(16'hFE04, 1'b0, 16'h0, 0, 1'b0, 16'h0);
        check("t4_dsr_ready", 32'(o_mdr), 32'h8000);
        idle(1);

        // timeouts
        access(16'h3100, 1'b0, 16'h7777, 7, 1'b0, 16'h0);
        check("t5_mdr_zero", 32'(o_mdr), 32'h0000);
        access(16'h3200, 1'b1, 16'h9999, 6, 1'b0, 16'h0);
        check("t5_no_write", 32'(e_mem.exists(16'h3200)), 32'd0);
        idle(1);

        // same-cycle LD.MAR and MEM.EN: access uses the old MAR
        access(16'h3300, 1'b1, 16'hCAFE, 0, 1'b1, 16'h3400);
        check("old_mar_mem", 32'(e_mem[16'h3300]), 32'hCAFE);
        check("old_mar_reg", 32'(o_mar), 32'h3400);
        idle(1);

        // reset while waiting on memory
        quiet = 1'b0;
        i_ld_mar = 1'b1; i_mar_in = 16'h4000;
        @(posedge i_clk); #1;
        i_ld_mar = 1'b0; i_mem_en = 1'b1; i_rw = 1'b0; resp_delay = 1000;
        @(posedge i_clk); #1;
        i_mem_en = 1'b0;
        @(negedge i_clk);
        check("t5_req_before_rst", 32'(o_mem_req), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("t5_req_in_rst", 32'(o_mem_req), 32'd0);
        check("t5_mar_in_rst", 32'(o_mar),     32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        mdl_reset();
        seen = 1'b0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_ready) seen = 1'b1;
        end
        check("t5_no_ready_after_rst", 32'(seen), 32'd0);
        #1 quiet = 1'b1;
        idle(1);

        // MCR and keyboard interrupt
        access(16'hFFFE, 1'b1, 16'h0000, 0, 1'b0, 16'h0);
        check("t6_mcr_run", 32'(o_mcr_run), 32'd0);
        access(16'hFE00, 1'b1, 16'h4000, 0, 1'b0, 16'h0);
        kb_send(8'h5A);
        idle(1);
        check("t6_kb_irq", 32'(o_kb_irq), 32'd1);

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                kb_send(8'($urandom));
            end else if (r < 3) begin
                dd_consume();
            end else begin
                if ($urandom_range(0, 9) < 6) a = mem_tbl[$urandom_range(0, 5)];
                else                          a = mmio_tbl[$urandom_range(0, 7)];
                access(a, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 6),
                       ($urandom_range(0, 3) == 0), 16'($urandom));
            end
            idle($urandom_range(1, 2));
        end

        quiet = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
